// File: rtl/vga_frame_tx.sv
// VGA transmit end: pixel-tick timing generator with HSYNC/VSYNC, a pixel FIFO fed by a
// valid/ready stream, and registered RGB332 outputs with a sticky underflow flag.
//
// FSM (one instance per axis, horizontal and vertical):
//   state     | meaning
//   PH_ACTIVE | counter inside the visible region
//   PH_FRONT  | front porch, blanking before sync
//   PH_SYNC   | sync pulse asserted
//   PH_BACK   | back porch, blanking after sync
module vga_frame_tx #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       EN,
  input  logic [7:0] PIX_DATA,
  input  logic       PIX_VALID,
  output logic       PIX_READY,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic [2:0] VGARED,
  output logic [2:0] VGAGREEN,
  output logic [1:0] VGABLUE,
  output logic       FRAME_START,
  output logic       UNDERFLOW,
  input  logic       CLR_UNDERFLOW
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_FP_LAST   = HW'(H_ACTIVE + H_FP - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_FP_LAST   = VW'(V_ACTIVE + V_FP - 1);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          tick;
  logic          line_end;
  phase_t        h_state, h_next;
  phase_t        v_state, v_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, starve, active_tick, fifo_empty;

  assign tick     = EN && (div == DIV_LAST);
  assign line_end = tick && (hcnt == H_LAST);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else if (!EN) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      div <= '0;
      if (line_end) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // Phase boundaries are taken on the tick that leaves the last count of each region.
  always_comb begin
    h_next = h_state;
    if (!EN) begin
      h_next = PH_ACTIVE;
    end else if (tick) begin
      case (h_state)
        PH_ACTIVE: if (hcnt == H_ACT_LAST)  h_next = PH_FRONT;
        PH_FRONT:  if (hcnt == H_FP_LAST)   h_next = PH_SYNC;
        PH_SYNC:   if (hcnt == H_SYNC_LAST) h_next = PH_BACK;
        PH_BACK:   if (hcnt == H_LAST)      h_next = PH_ACTIVE;
        default:                            h_next = PH_ACTIVE;
      endcase
    end
  end

  always_comb begin
    v_next = v_state;
    if (!EN) begin
      v_next = PH_ACTIVE;
    end else if (line_end) begin
      case (v_state)
        PH_ACTIVE: if (vcnt == V_ACT_LAST)  v_next = PH_FRONT;
        PH_FRONT:  if (vcnt == V_FP_LAST)   v_next = PH_SYNC;
        PH_SYNC:   if (vcnt == V_SYNC_LAST) v_next = PH_BACK;
        PH_BACK:   if (vcnt == V_LAST)      v_next = PH_ACTIVE;
        default:                            v_next = PH_ACTIVE;
      endcase
    end
  end

  assign PIX_READY   = RESETn && (count != FULL_CNT);
  assign fifo_empty  = (count == '0);
  assign push        = PIX_VALID && PIX_READY;
  assign active_tick = tick && (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);
  assign pop         = active_tick && !fifo_empty;
  assign starve      = active_tick && fifo_empty;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= PIX_DATA;
  end

  // A pop decides on the pre-edge count, so a push into an empty FIFO cannot feed the same tick.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      HSYNC                        <= ~SYNC_POL;
      VSYNC                        <= ~SYNC_POL;
      {VGARED, VGAGREEN, VGABLUE}  <= 8'h00;
      FRAME_START                  <= 1'b0;
    end else if (!EN) begin
      HSYNC                        <= ~SYNC_POL;
      VSYNC                        <= ~SYNC_POL;
      {VGARED, VGAGREEN, VGABLUE}  <= 8'h00;
      FRAME_START                  <= 1'b0;
    end else begin
      FRAME_START <= tick && (hcnt == '0) && (vcnt == '0);
      if (tick) begin
        HSYNC                       <= (h_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        VSYNC                       <= (v_state == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        {VGARED, VGAGREEN, VGABLUE} <= pop ? mem[rd_ptr] : 8'h00;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn)            UNDERFLOW <= 1'b0;
    else if (starve)        UNDERFLOW <= 1'b1;
    else if (CLR_UNDERFLOW) UNDERFLOW <= 1'b0;
  end

endmodule
